home_status_decoder: RTL and testbench

- Receiving end of the home-automation scanner's rotating status stream: samples the 3-bit event code the scanner emits each slot (0 none, 1 front door, 2 rear door, 3 fire, 4 window, 5 heater, 6 cooler).
- Rebuilds persistent per-channel actuator/LED levels with hold timers and latches the fire alarm until acknowledged.
- Drives a single prioritised display code for the panel.
- Sits between the scanner and the front-panel / actuator drivers.

---
 rtl/home_pkg.sv | 41 ++++
 rtl/home_status_decoder_hold_timer.sv | 37 +++
 rtl/home_status_decoder.sv | 147 ++++++++++++++
 tb/tb_home_status_decoder.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/home_pkg.sv
// Shared codes, channel indices and display priority for the home status decoder.
package home_pkg;

  localparam int unsigned CODE_W = 3;
  localparam int unsigned NUM_CH = 6;
  localparam int unsigned NUM_CODES = 8;

  typedef logic [CODE_W-1:0] code_t;

  localparam code_t CODE_NONE    = 3'd0;
  localparam code_t CODE_FDOOR   = 3'd1;
  localparam code_t CODE_RDOOR   = 3'd2;
  localparam code_t CODE_FIRE    = 3'd3;
  localparam code_t CODE_WIN     = 3'd4;
  localparam code_t CODE_HEAT    = 3'd5;
  localparam code_t CODE_COOL    = 3'd6;
  localparam code_t CODE_ILLEGAL = 3'd7;

  // Channel index is code - 1.
  localparam int unsigned CH_FDOOR = 0;
  localparam int unsigned CH_RDOOR = 1;
  localparam int unsigned CH_FIRE  = 2;
  localparam int unsigned CH_WIN   = 3;
  localparam int unsigned CH_HEAT  = 4;
  localparam int unsigned CH_COOL  = 5;

  // Display order, highest priority in the most significant slot.
  localparam logic [NUM_CH*CODE_W-1:0] DISP_PRIO =
    {CODE_FIRE, CODE_FDOOR, CODE_RDOOR, CODE_WIN, CODE_HEAT, CODE_COOL};

  // Returns the highest-priority code whose activity bit is set, else CODE_NONE.
  function automatic code_t disp_pick(input logic [NUM_CODES-1:0] act);
    code_t c;
    disp_pick = CODE_NONE;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      c = DISP_PRIO[i*CODE_W +: CODE_W];
      if (act[c]) disp_pick = c;
    end
  endfunction

endpackage

// File: rtl/home_status_decoder_hold_timer.sv
// hold_timer: per-channel retrigger timer; load wins over clear, otherwise counts down to 0.
module hold_timer #(
  parameter int unsigned HOLD_CYCLES = 12,
  parameter int unsigned HOLD_W      = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic clear,
  output logic active,
  output logic active_nxt_c
);

  logic [HOLD_W-1:0] cnt_q, cnt_d;
  logic              active_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load)              cnt_d = HOLD_W'(HOLD_CYCLES);
    else if (clear)        cnt_d = '0;
    else if (cnt_q != '0)  cnt_d = cnt_q - HOLD_W'(1);
    active_nxt_c = (cnt_d != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      active_q <= active_nxt_c;
    end
  end

  assign active = active_q;

endmodule

// File: rtl/home_status_decoder.sv
// Rebuilds held channel levels, fire latch and panel display from the scanner code stream.
// Optional alarm blink enabled by defining HOME_STATUS_DEC_BLINK_EN.
module home_status_decoder
  import home_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 12,
  parameter int unsigned HOLD_W      = 4
`ifdef HOME_STATUS_DEC_BLINK_EN
  , parameter int unsigned BLINK_DIV = 8
`endif
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic [CODE_W-1:0] code_in,
  input  logic              Ack,
  output logic              fdoor,
  output logic              rdoor,
  output logic              winbuzz,
  output logic              heater,
  output logic              cooler,
  output logic              alarmbuzz,
  output logic [CODE_W-1:0] disp_out,
  output logic              err_sticky,
  output logic [7:0]        fire_cnt
);

  logic [NUM_CH-1:0] act;
  logic [NUM_CH-1:0] act_nxt;

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    logic clr;
    // Heater and cooler are mutually exclusive: each code kills the other channel.
    assign clr = (ch == CH_HEAT) ? (code_in == CODE_COOL) :
                 (ch == CH_COOL) ? (code_in == CODE_HEAT) : 1'b0;

    hold_timer #(
      .HOLD_CYCLES (HOLD_CYCLES),
      .HOLD_W      (HOLD_W)
    ) u_hold (
      .clk          (Clk),
      .rst_n        (Rst),
      .load         (code_in == code_t'(ch + 1)),
      .clear        (clr),
      .active       (act[ch]),
      .active_nxt_c (act_nxt[ch])
    );
  end

  logic                 latch_q, latch_d;
  logic                 err_q, err_d;
  logic [7:0]           fire_cnt_q, fire_cnt_d;
  code_t                disp_q, disp_d;
  logic [NUM_CODES-1:0] disp_act;

  // Fire latch, episode counter and illegal-code flag.
  always_comb begin
    latch_d    = latch_q;
    err_d      = err_q;
    fire_cnt_d = fire_cnt_q;

    if (code_in == CODE_FIRE)        latch_d = 1'b1;
    else if (Ack && !act[CH_FIRE])   latch_d = 1'b0;

    if (!latch_q && latch_d && fire_cnt_q != 8'hFF)
      fire_cnt_d = fire_cnt_q + 8'd1;

    if (code_in == CODE_ILLEGAL)     err_d = 1'b1;
    else if (Ack)                    err_d = 1'b0;
  end

  // Display tracks next-state activity so it lines up with the channel outputs.
  always_comb begin
    disp_act              = '0;
    disp_act[CODE_FDOOR]  = act_nxt[CH_FDOOR];
    disp_act[CODE_RDOOR]  = act_nxt[CH_RDOOR];
    disp_act[CODE_FIRE]   = latch_d | act_nxt[CH_FIRE];
    disp_act[CODE_WIN]    = act_nxt[CH_WIN];
    disp_act[CODE_HEAT]   = act_nxt[CH_HEAT];
    disp_act[CODE_COOL]   = act_nxt[CH_COOL];
    disp_d                = disp_pick(disp_act);
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      latch_q    <= 1'b0;
      err_q      <= 1'b0;
      fire_cnt_q <= '0;
      disp_q     <= CODE_NONE;
    end else begin
      latch_q    <= latch_d;
      err_q      <= err_d;
      fire_cnt_q <= fire_cnt_d;
      disp_q     <= disp_d;
    end
  end

  logic buzz_q, buzz_d;

`ifdef HOME_STATUS_DEC_BLINK_EN
  localparam int unsigned DIV_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [DIV_W-1:0] div_q, div_d;

  // Blink phase restarts high on the cycle after the latch sets.
  always_comb begin
    div_d  = div_q;
    buzz_d = buzz_q;
    if (!latch_d) begin
      div_d  = '0;
      buzz_d = 1'b0;
    end else if (!latch_q) begin
      div_d  = '0;
      buzz_d = 1'b1;
    end else if (div_q == DIV_W'(BLINK_DIV - 1)) begin
      div_d  = '0;
      buzz_d = ~buzz_q;
    end else begin
      div_d  = div_q + DIV_W'(1);
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) div_q <= '0;
    else      div_q <= div_d;
  end
`else
  always_comb begin
    buzz_d = latch_d;
  end
`endif

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) buzz_q <= 1'b0;
    else      buzz_q <= buzz_d;
  end

  assign fdoor      = act[CH_FDOOR];
  assign rdoor      = act[CH_RDOOR];
  assign winbuzz    = act[CH_WIN];
  assign heater     = act[CH_HEAT];
  assign cooler     = act[CH_COOL];
  assign alarmbuzz  = buzz_q;
  assign disp_out   = disp_q;
  assign err_sticky = err_q;
  assign fire_cnt   = fire_cnt_q;

endmodule

// File: tb/tb_home_status_decoder.sv
// Directed bench for home_status_decoder in its default (steady alarm) build.
module tb_home_status_decoder;

  logic       Clk = 1'b0;
  logic       Rst;
  logic [2:0] code_in;
  logic       Ack;
  logic       fdoor, rdoor, winbuzz, heater, cooler, alarmbuzz, err_sticky;
  logic [2:0] disp_out;
  logic [7:0] fire_cnt;

  int n_vec = 0;
  int n_err = 0;

  home_status_decoder #(.HOLD_CYCLES(12), .HOLD_W(4)) dut (
    .Clk        (Clk),
    .Rst        (Rst),
    .code_in    (code_in),
    .Ack        (Ack),
    .fdoor      (fdoor),
    .rdoor      (rdoor),
    .winbuzz    (winbuzz),
    .heater     (heater),
    .cooler     (cooler),
    .alarmbuzz  (alarmbuzz),
    .disp_out   (disp_out),
    .err_sticky (err_sticky),
    .fire_cnt   (fire_cnt)
  );

  always #5 Clk = ~Clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Present inputs for one edge, then return them to idle 1 ns after it.
  task automatic step(input logic [2:0] c, input logic a);
    code_in = c;
    Ack     = a;
    @(posedge Clk);
    #1;
    code_in = 3'd0;
    Ack     = 1'b0;
  endtask

  initial begin
    Rst     = 1'b0;
    code_in = 3'd0;
    Ack     = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    check_eq("rst_fdoor", 32'(fdoor), 0);
    check_eq("rst_alarm", 32'(alarmbuzz), 0);
    check_eq("rst_disp", 32'(disp_out), 0);
    check_eq("rst_err", 32'(err_sticky), 0);
    check_eq("rst_firecnt", 32'(fire_cnt), 0);
    Rst = 1'b1;
    repeat (3) step(3'd0, 1'b0);

    // Single front-door code holds for exactly 12 cycles.
    step(3'd1, 1'b0);
    for (int k = 1; k <= 13; k++) begin
      check_eq("fdoor_hold", 32'(fdoor), (k <= 12) ? 32'd1 : 32'd0);
      check_eq("fdoor_disp", 32'(disp_out), (k <= 12) ? 32'd1 : 32'd0);
      step(3'd0, 1'b0);
    end

    // Heater then cooler: handover on the same edge.
    step(3'd5, 1'b0);
    check_eq("heat_on", 32'(heater), 1);
    check_eq("heat_disp", 32'(disp_out), 5);
    step(3'd0, 1'b0);
    step(3'd6, 1'b0);
    check_eq("heat_off", 32'(heater), 0);
    check_eq("cool_on", 32'(cooler), 1);
    check_eq("cool_disp", 32'(disp_out), 6);
    step(3'd4, 1'b0);
    check_eq("prio_win", 32'(disp_out), 4);
    step(3'd2, 1'b0);
    check_eq("prio_rear", 32'(disp_out), 2);
    step(3'd1, 1'b0);
    check_eq("prio_front", 32'(disp_out), 1);
    for (int k = 0; k < 14; k++) begin
      check_eq("heat_cool_excl", 32'(heater & cooler), 0);
      step(3'd0, 1'b0);
    end
    check_eq("drained_disp", 32'(disp_out), 0);

    // Fire episode: Ack ignored while the fire counter runs.
    step(3'd3, 1'b0);
    check_eq("fire_alarm", 32'(alarmbuzz), 1);
    check_eq("fire_cnt1", 32'(fire_cnt), 1);
    check_eq("fire_disp", 32'(disp_out), 3);
    repeat (4) step(3'd0, 1'b0);
    step(3'd0, 1'b1);
    check_eq("ack_early", 32'(alarmbuzz), 1);
    repeat (6) step(3'd0, 1'b0);
    step(3'd0, 1'b1);
    check_eq("ack_cnt1", 32'(alarmbuzz), 1);
    check_eq("disp_latched", 32'(disp_out), 3);
    step(3'd0, 1'b1);
    check_eq("ack_clear", 32'(alarmbuzz), 0);
    check_eq("ack_disp", 32'(disp_out), 0);
    check_eq("fire_cnt_keep", 32'(fire_cnt), 1);

    // Fire and Ack together: set wins, second episode counted.
    step(3'd3, 1'b1);
    check_eq("set_wins", 32'(alarmbuzz), 1);
    check_eq("fire_cnt2", 32'(fire_cnt), 2);
    repeat (12) step(3'd0, 1'b0);
    step(3'd0, 1'b1);
    check_eq("clear2", 32'(alarmbuzz), 0);

    // Saturation at 255.
    for (int e = 0; e < 254; e++) begin
      step(3'd3, 1'b0);
      repeat (12) step(3'd0, 1'b0);
      step(3'd0, 1'b1);
    end
    check_eq("fire_cnt_sat", 32'(fire_cnt), 255);
    check_eq("sat_alarm_off", 32'(alarmbuzz), 0);

    // Illegal code: flag only, channels untouched.
    step(3'd1, 1'b0);
    step(3'd7, 1'b0);
    check_eq("err_set", 32'(err_sticky), 1);
    check_eq("err_fdoor", 32'(fdoor), 1);
    check_eq("err_disp", 32'(disp_out), 1);
    step(3'd7, 1'b1);
    check_eq("err_set_wins", 32'(err_sticky), 1);
    step(3'd0, 1'b1);
    check_eq("err_clear", 32'(err_sticky), 0);

    // Asynchronous reset mid-hold.
    step(3'd2, 1'b0);
    check_eq("rdoor_on", 32'(rdoor), 1);
    #3;
    Rst = 1'b0;
    #1;
    check_eq("arst_rdoor", 32'(rdoor), 0);
    check_eq("arst_fdoor", 32'(fdoor), 0);
    check_eq("arst_disp", 32'(disp_out), 0);
    check_eq("arst_firecnt", 32'(fire_cnt), 0);
    #1;
    Rst = 1'b1;
    step(3'd0, 1'b0);
    check_eq("post_rst_rdoor", 32'(rdoor), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
